// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO and a sticky overflow flag.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx_port #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [8:0] din,
    output logic [8:0] status,
    output logic       tx
);

    localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0]  FULL_CNT  = 3'(FIFO_DEPTH);
    localparam logic [11:0] BAUD_LAST = 12'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ovf_q, ovf_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    logic fifo_empty, fifo_full, baud_end, pop, push;

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign baud_end   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 12'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = par_q;
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Pop straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_d   = ^mem_q[rd_ptr_q];
`endif
        end

        // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
        push  = wr_en & ~din[8] & (~fifo_full | pop);
        ovf_d = ovf_q;
        if (wr_en && din[8])
            ovf_d = 1'b0;
        else if (wr_en && fifo_full && !pop)
            ovf_d = 1'b1;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + 3'(push) - 3'(pop);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= din[7:0];
    end

`ifdef UART_TX_PARITY_EN
    assign status = {1'b1, ovf_q, count_q, fifo_empty, fifo_full, (state_q != IDLE)};
`else
    assign status = {1'b0, ovf_q, count_q, fifo_empty, fifo_full, (state_q != IDLE)};
`endif
    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: a frame-timing model predicts pops and status,
// and a line monitor decodes tx and checks each frame against the expected queue.
module tb_uart_tx_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int   NBITS    = 11;
    localparam logic PAR_FLAG = 1'b1;
`else
    localparam int   NBITS    = 10;
    localparam logic PAR_FLAG = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en  = 1'b0;
    logic [8:0] din    = '0;
    logic [8:0] status;
    logic       tx;

    uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .wr_en  (wr_en),
        .din    (din),
        .status (status),
        .tx     (tx)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] q_m[$];
    frame_t     exp_q[$];
    logic       ovf_m = 1'b0;
    int         next_free = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the transmitter can take a new byte once a full frame has elapsed since its last pop.
    frame_t     f_new;
    logic [8:0] exp_status;
    always @(posedge clock) begin
        cyc++;
        if (!resetn) begin
            q_m.delete();
            exp_q.delete();
            ovf_m     = 1'b0;
            next_free = 0;
        end else begin
            if (q_m.size() > 0 && cyc >= next_free) begin
                f_new.data  = q_m.pop_front();
                f_new.start = cyc + 1;
                exp_q.push_back(f_new);
                next_free = cyc + FRAME;
            end
            if (wr_en) begin
                if (din[8])
                    ovf_m = 1'b0;
                else if (q_m.size() < DEPTH)
                    q_m.push_back(din[7:0]);
                else
                    ovf_m = 1'b1;
            end
        end
        exp_status = {PAR_FLAG, ovf_m, 3'(q_m.size()), (q_m.size() == 0),
                      (q_m.size() == DEPTH), (cyc < next_free)};
        #1;
        chk("status", status, exp_status);
    end

    // Line monitor: detect start bit, sample each bit mid-period, compare against the scoreboard.
    logic        mon_act = 1'b0;
    int          mon_st  = 0;
    logic [10:0] mon_bits;
    frame_t      f_got;
    always @(negedge clock) begin
        if (!resetn) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && tx === 1'b0) begin
                mon_act = 1'b1;
                mon_st  = cyc;
            end
            if (mon_act && ((cyc - mon_st) % CPB) == CPB / 2) begin
                mon_bits[(cyc - mon_st) / CPB] = tx;
                if ((cyc - mon_st) / CPB == NBITS - 1) begin
                    mon_act = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        f_got = exp_q.pop_front();
                        chk("frame_start_cycle", mon_st, f_got.start);
                        chk("start_bit", mon_bits[0], 1'b0);
                        chk("data_byte", mon_bits[8:1], f_got.data);
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", mon_bits[9], ^f_got.data);
`endif
                        chk("stop_bit", mon_bits[NBITS-1], 1'b1);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [8:0] d);
        wr_en = 1'b1;
        din   = d;
        @(negedge clock);
        wr_en = 1'b0;
        din   = '0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (q_m.size() == 0 && exp_q.size() == 0 && cyc >= next_free && !mon_act) begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!done) chk("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_tx", tx, 1'b1);
        chk("reset_status", status, {PAR_FLAG, 8'b00000100});
        resetn = 1'b1;
        @(negedge clock);

        wr(9'h055);
        wait_idle();
        chk("idle_status", status, {PAR_FLAG, 8'b00000100});

        wr(9'h041);
        wr(9'h042);
        wr(9'h043);
        wait_idle();

        wr(9'h000);
        for (int i = 0; i < 5; i++) wr({1'b0, 8'($urandom)});
        chk("ovf_set", status[6], 1'b1);
        chk("ovf_count_full", status[5:3], 3'd4);
        chk("ovf_full_flag", status[1], 1'b1);
        wr(9'h1FF);
        chk("ovf_cleared", status[6], 1'b0);
        chk("ovf_clear_count", status[5:3], 3'd4);

        // Line up a write with the edge where STOP pops the next byte.
        for (int i = 0; i < 200; i++) begin
            if (cyc + 1 == next_free) break;
            @(negedge clock);
        end
        chk("collision_setup_full", status[5:3], 3'd4);
        wr({1'b0, 8'($urandom)});
        chk("collision_count", status[5:3], 3'd4);
        chk("collision_no_ovf", status[6], 1'b0);
        wait_idle();

        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 50)) @(negedge clock);
            if ($urandom_range(0, 9) == 0) wr(9'h100);
            else                           wr({1'b0, 8'($urandom)});
        end
        wait_idle();

        wr(9'h007);
        wr(9'h003);
        wait_idle();

        wr(9'h0C3);
        repeat (4 * CPB + 1) @(negedge clock);
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        chk("midframe_reset_tx", tx, 1'b1);
        chk("midframe_reset_status", status, {PAR_FLAG, 8'b00000100});
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("post_reset_tx", tx, 1'b1);
        wr(9'h0A5);
        wait_idle();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
